// File: rtl/mac_bias_lif_seq_if.sv
// Frame/result handshake bundle for the time-multiplexed MAC + bias + LIF neuron.
// master = spike/weight buffer side, slave = neuron.
interface mac_bias_lif_seq_if #(
  parameter int S     = 25,
  parameter int WIDTH = 8,
  parameter int MEM_W = 12
);
  logic                 in_valid;
  logic                 in_ready;
  logic [S-1:0]         pixels;
  logic [S*WIDTH-1:0]   weights;
  logic [WIDTH-1:0]     bias;
  logic [MEM_W-1:0]     threshold;
  logic                 clear_mem;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     sum_out;
  logic [MEM_W-1:0]     membrane;
  logic                 spike;

  modport master (
    output in_valid, pixels, weights, bias, threshold, clear_mem, out_ready,
    input  in_ready, out_valid, sum_out, membrane, spike
  );
  modport slave (
    input  in_valid, pixels, weights, bias, threshold, clear_mem, out_ready,
    output in_ready, out_valid, sum_out, membrane, spike
  );
endinterface

// File: rtl/mac_bias_lif_seq.sv
// Time-multiplexed spiking neuron: LANES synapses per cycle into a signed accumulator,
// saturating bias add, then a leaky integrate-and-fire membrane with threshold reset.
module mac_bias_lif_lane #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16
) (
  input  logic             pix,
  input  logic [WIDTH-1:0] w,
  output logic [ACC_W-1:0] prod
);
  assign prod = pix ? {{(ACC_W-WIDTH){w[WIDTH-1]}}, w} : '0;
endmodule

module mac_bias_lif_seq #(
  parameter int S       = 25,
  parameter int WIDTH   = 8,
  parameter int LANES   = 5,
  parameter int ACC_W   = 16,
  parameter int MEM_W   = 12,
  parameter int LEAK_SH = 3
) (
  input logic              clk,
  input logic              rst_n,
  mac_bias_lif_seq_if.slave bus
);
  localparam int NCHUNK = (S + LANES - 1) / LANES;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic signed [ACC_W:0] S_MAX = {{(ACC_W-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W:0] S_MIN = {{(ACC_W-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [MEM_W:0] M_MAX = {2'b00, {(MEM_W-1){1'b1}}};
  localparam logic signed [MEM_W:0] M_MIN = {2'b11, {(MEM_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, FIRE, HOLD} state_t;

  typedef struct packed {
    logic [S-1:0]       pix;
    logic [S*WIDTH-1:0] w;
    logic [WIDTH-1:0]   bias;
  } frame_t;

  state_t                   state, state_nx;
  frame_t                   frame_q;
  logic [CNT_W-1:0]         cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [WIDTH-1:0]  sum_q;
  logic signed [MEM_W-1:0]  mem_q;
  logic                     spike_q;

  logic [NCHUNK-1:0][LANES-1:0]            pix_pad;
  logic [NCHUNK-1:0][LANES-1:0][WIDTH-1:0] w_pad;
  logic [LANES-1:0][ACC_W-1:0]             lane_prod;
  logic [ACC_W-1:0]                        chunk_sum;
  logic                                    last_chunk;

  // Reshape the flat frame into chunk x lane; slots past S stay zero so tail lanes add nothing.
  always_comb begin
    pix_pad = '0;
    w_pad   = '0;
    for (int i = 0; i < S; i++) begin
      pix_pad[i / LANES][i % LANES] = frame_q.pix[i];
      w_pad[i / LANES][i % LANES]   = frame_q.w[i*WIDTH +: WIDTH];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_bias_lif_lane #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_lane (
      .pix  (pix_pad[cnt][l]),
      .w    (w_pad[cnt][l]),
      .prod (lane_prod[l])
    );
  end

  always_comb begin
    chunk_sum = '0;
    for (int l = 0; l < LANES; l++) chunk_sum = chunk_sum + lane_prod[l];
  end

  assign last_chunk = (cnt == CNT_W'(NCHUNK - 1));

  // Bias add and membrane update are one bit wider so saturation sees the true sum.
  logic signed [ACC_W:0]   bsum;
  logic signed [WIDTH-1:0] s_sat;
  logic signed [MEM_W-1:0] v_leak, v_next;
  logic signed [MEM_W:0]   vsum;
  logic                    fire;

  assign bsum  = {acc[ACC_W-1], acc} + {{(ACC_W+1-WIDTH){frame_q.bias[WIDTH-1]}}, frame_q.bias};
  assign s_sat = (bsum > S_MAX) ? S_MAX[WIDTH-1:0] :
                 (bsum < S_MIN) ? S_MIN[WIDTH-1:0] : bsum[WIDTH-1:0];

  if (LEAK_SH == 0) begin : g_noleak
    assign v_leak = mem_q;
  end else begin : g_leak
    assign v_leak = mem_q - (mem_q >>> LEAK_SH);
  end

  assign vsum   = {v_leak[MEM_W-1], v_leak} + {{(MEM_W+1-WIDTH){s_sat[WIDTH-1]}}, s_sat};
  assign v_next = (vsum > M_MAX) ? M_MAX[MEM_W-1:0] :
                  (vsum < M_MIN) ? M_MIN[MEM_W-1:0] : vsum[MEM_W-1:0];
  assign fire   = (v_next >= $signed(bus.threshold));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = ACCUM;
      end
      ACCUM: if (last_chunk) state_nx = FIRE;
      FIRE:  state_nx = HOLD;
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
      cnt     <= '0;
      acc     <= '0;
      sum_q   <= '0;
      mem_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            frame_q <= '{pix: bus.pixels, w: bus.weights, bias: bus.bias};
            acc     <= '0;
            cnt     <= '0;
          end else if (bus.clear_mem) begin
            mem_q <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + $signed(chunk_sum);
          cnt <= last_chunk ? '0 : cnt + 1'b1;
        end
        FIRE: begin
          sum_q   <= s_sat;
          spike_q <= fire;
          mem_q   <= fire ? '0 : v_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.sum_out  = sum_q;
  assign bus.membrane = mem_q;
  assign bus.spike    = spike_q;
endmodule

// File: tb/tb_mac_bias_lif_seq.sv
// Directed + randomized bench for mac_bias_lif_seq against a frame-level arithmetic model.
module tb_mac_bias_lif_seq;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mac_bias_lif_seq_if #(.S(25), .WIDTH(8), .MEM_W(12)) b0 ();
  mac_bias_lif_seq_if #(.S(7),  .WIDTH(8), .MEM_W(12)) b1 ();

  mac_bias_lif_seq #(.S(25), .WIDTH(8), .LANES(5), .ACC_W(16), .MEM_W(12), .LEAK_SH(3))
    u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  mac_bias_lif_seq #(.S(7), .WIDTH(8), .LANES(3), .ACC_W(16), .MEM_W(12), .LEAK_SH(3))
    u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  int errs = 0;
  int checks = 0;
  int v0 = 0;
  int v1 = 0;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int x, input int lo, input int hi);
    return (x > hi) ? hi : (x < lo) ? lo : x;
  endfunction

  // One whole frame from the behavioural rules: dot product, clamp, leak, clamp, threshold.
  function automatic void model(input int n, input bit [24:0] p, input int w[25], input int b,
                                input int thr, inout int v, output int s, output bit sp);
    int acc = 0;
    int vl, vn;
    for (int i = 0; i < n; i++) if (p[i]) acc += w[i];
    s  = clamp(acc + b, -128, 127);
    vl = v - (v >>> 3);
    vn = clamp(vl + s, -2048, 2047);
    sp = (vn >= thr);
    v  = sp ? 0 : vn;
  endfunction

  task automatic frame0(input string tag, input bit [24:0] p, input int w[25], input int b,
                        input int thr, input bit hold);
    int s, lat;
    bit sp;
    @(negedge clk);
    check({tag, "/in_ready_idle"}, b0.in_ready, 1);
    b0.pixels = p;
    for (int i = 0; i < 25; i++) b0.weights[i*8 +: 8] = w[i][7:0];
    b0.bias = b[7:0];
    b0.threshold = thr[11:0];
    b0.in_valid = 1'b1;
    @(posedge clk); #1;
    b0.in_valid = 1'b0;
    b0.pixels = 25'($urandom);
    for (int i = 0; i < 25; i++) b0.weights[i*8 +: 8] = 8'($urandom);
    b0.bias = 8'($urandom);
    model(25, p, w, b, thr, v0, s, sp);
    lat = 0;
    while (b0.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, lat, 6);
    check({tag, "/sum_out"}, $signed(b0.sum_out), s);
    check({tag, "/membrane"}, $signed(b0.membrane), v0);
    check({tag, "/spike"}, b0.spike, sp);
    check({tag, "/in_ready_busy"}, b0.in_ready, 0);
    if (hold) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        b0.in_valid  = 1'b1;
        b0.clear_mem = 1'b1;
        @(posedge clk); #1;
        check({tag, "/hold_valid"}, b0.out_valid, 1);
        check({tag, "/hold_in_ready"}, b0.in_ready, 0);
        check({tag, "/hold_sum"}, $signed(b0.sum_out), s);
        check({tag, "/hold_mem"}, $signed(b0.membrane), v0);
        check({tag, "/hold_spike"}, b0.spike, sp);
      end
    end
    @(negedge clk);
    b0.in_valid  = 1'b0;
    b0.clear_mem = 1'b0;
    b0.out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "/released_valid"}, b0.out_valid, 0);
    check({tag, "/released_ready"}, b0.in_ready, 1);
    check({tag, "/kept_mem"}, $signed(b0.membrane), v0);
    b0.out_ready = 1'b0;
  endtask

  task automatic frame1(input string tag, input bit [6:0] p, input int w[25], input int b,
                        input int thr);
    int s, lat;
    bit sp;
    @(negedge clk);
    b1.pixels = p;
    for (int i = 0; i < 7; i++) b1.weights[i*8 +: 8] = w[i][7:0];
    b1.bias = b[7:0];
    b1.threshold = thr[11:0];
    b1.in_valid = 1'b1;
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    b1.pixels = 7'($urandom);
    model(7, {18'b0, p}, w, b, thr, v1, s, sp);
    lat = 0;
    while (b1.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, lat, 4);
    check({tag, "/sum_out"}, $signed(b1.sum_out), s);
    check({tag, "/membrane"}, $signed(b1.membrane), v1);
    check({tag, "/spike"}, b1.spike, sp);
    @(negedge clk);
    b1.out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "/released"}, b1.out_valid, 0);
    b1.out_ready = 1'b0;
  endtask

  initial begin
    int w[25];
    bit [24:0] p;
    {b0.in_valid, b0.pixels, b0.weights, b0.bias, b0.threshold, b0.clear_mem, b0.out_ready} = '0;
    {b1.in_valid, b1.pixels, b1.weights, b1.bias, b1.threshold, b1.clear_mem, b1.out_ready} = '0;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/in_ready", b0.in_ready, 1);
    check("rst/out_valid", b0.out_valid, 0);
    check("rst/sum_out", b0.sum_out, 0);
    check("rst/membrane", b0.membrane, 0);
    check("rst/spike", b0.spike, 0);
    @(negedge clk) rst_n = 1'b1;

    foreach (w[i]) w[i] = 2;
    frame0("f1", '1, w, 3, 100, 1'b0);
    check("f1/sum_const", $signed(b0.sum_out), 53);
    frame0("f2", '1, w, 3, 100, 1'b0);
    check("f2/spike_const", b0.spike, 1);

    foreach (w[i]) w[i] = 127;
    frame0("sat_pos", '1, w, 127, 2047, 1'b0);
    check("sat_pos/const", $signed(b0.sum_out), 127);
    foreach (w[i]) w[i] = -128;
    frame0("sat_neg", '1, w, -128, 2047, 1'b0);
    check("sat_neg/const", $signed(b0.sum_out), -128);

    foreach (w[i]) w[i] = $urandom_range(0, 255) - 128;
    frame0("hold", 25'($urandom), w, $urandom_range(0, 255) - 128, 300, 1'b1);

    for (int r = 0; r < 10; r++) begin
      foreach (w[i]) w[i] = $urandom_range(0, 255) - 128;
      frame0($sformatf("rnd%0d", r), 25'($urandom), w, $urandom_range(0, 255) - 128,
             $urandom_range(0, 400) - 150, 1'b0);
    end

    // Abort a frame while chunk 3 is being accumulated.
    foreach (w[i]) w[i] = -100;
    frame0("pre_rst", '1, w, -50, 2047, 1'b0);
    @(negedge clk);
    b0.pixels = '1;
    b0.in_valid = 1'b1;
    @(posedge clk); #1;
    b0.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst/out_valid", b0.out_valid, 0);
    check("mid_rst/in_ready", b0.in_ready, 1);
    check("mid_rst/sum_out", b0.sum_out, 0);
    check("mid_rst/membrane", b0.membrane, 0);
    check("mid_rst/spike", b0.spike, 0);
    v0 = 0;
    v1 = 0;
    @(negedge clk) rst_n = 1'b1;
    foreach (w[i]) w[i] = 2;
    frame0("post_rst", '1, w, 3, 100, 1'b0);
    check("post_rst/mem_const", $signed(b0.membrane), 53);

    foreach (w[i]) w[i] = $urandom_range(0, 255) - 128;
    w[6] = -5;
    frame1("s7_pad", 7'b1000000, w, 0, 100);
    check("s7_pad/sum_const", $signed(b1.sum_out), -5);
    check("s7_pad/mem_const", $signed(b1.membrane), -5);

    @(negedge clk) b1.clear_mem = 1'b1;
    @(posedge clk); #1;
    check("s7_clear/membrane", b1.membrane, 0);
    v1 = 0;
    b1.clear_mem = 1'b0;

    for (int r = 0; r < 6; r++) begin
      foreach (w[i]) w[i] = $urandom_range(0, 255) - 128;
      frame1($sformatf("s7_rnd%0d", r), 7'($urandom), w, $urandom_range(0, 255) - 128,
             $urandom_range(0, 300) - 100);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
